// File: rtl/uart_tx_ser.sv
// UART transmit serializer: one word per valid/ready handshake, sent LSB-first
// as start, data, optional parity and stop bits, one bit per baud_trig_tx tick.
module uart_tx_ser #(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_trig_tx,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic            par_en,
  input  logic            par_odd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int unsigned   CW        = $clog2(DBIT);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DBIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [DBIT-1:0] shreg;
  logic            par_q;
  logic            par_bit;
  logic [CW-1:0]   bit_cnt;
  logic            stop_cnt;
  logic            accept;

  assign accept = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      par_q    <= 1'b0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        // tx_ready stays low for the first IDLE cycle after a frame, so it
        // rises the cycle after tx_done.
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shreg    <= tx_data;
            par_q    <= par_en;
            par_bit  <= ^tx_data ^ par_odd;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= ARM;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        ARM: begin
          if (baud_trig_tx) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_trig_tx) begin
            tx      <= shreg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        // The word shifts right so the next data bit is always at index 1.
        DATA: begin
          if (baud_trig_tx) begin
            if (bit_cnt != LAST_BIT) begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[1];
              shreg   <= shreg >> 1;
            end else if (par_q) begin
              tx    <= par_bit;
              state <= PARITY;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
        end
        PARITY: begin
          if (baud_trig_tx) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_trig_tx) begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Self-checking bench for uart_tx_ser: one-stop and two-stop instances share
// the input bus; frames are captured tick by tick and compared to expected bits.
module tb_uart_tx_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tick;
  logic [7:0] tx_data;
  logic       par_en, par_odd;
  logic       valid_a, valid_b;
  logic       rdy_a, tx_a, busy_a, done_a;
  logic       rdy_b, tx_b, busy_b, done_b;

  bit   cur;
  logic s_tx, s_ready, s_busy, s_done;
  assign s_tx    = cur ? tx_b   : tx_a;
  assign s_ready = cur ? rdy_b  : rdy_a;
  assign s_busy  = cur ? busy_b : busy_a;
  assign s_done  = cur ? done_b : done_a;

  uart_tx_ser #(.DBIT(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .baud_trig_tx(tick), .tx_data(tx_data),
    .tx_valid(valid_a), .tx_ready(rdy_a), .par_en(par_en), .par_odd(par_odd),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx_ser #(.DBIT(8), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .baud_trig_tx(tick), .tx_data(tx_data),
    .tx_valid(valid_b), .tx_ready(rdy_b), .par_en(par_en), .par_odd(par_odd),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick: one clk wide every div clks, changed shortly after posedge.
  int div = 16;
  int tcnt = 0;
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (div <= 1) begin
        tick = 1'b1;
      end else begin
        tcnt = (tcnt + 1) % div;
        tick = (tcnt == 0);
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Expected frame, transmission order, left-justified in 16 bits.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input bit pe, input bit po,
                                              input int stops, output int len);
    bit q[$];
    logic [15:0] f;
    f = '0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(bit'(($countones(d) + int'(po)) % 2));
    repeat (stops) q.push_back(1'b1);
    len = q.size();
    foreach (q[i]) f[15-i] = q[i];
    return f;
  endfunction

  task automatic accept_word(input bit sel, input logic [7:0] d, input bit pe, input bit po,
                             input bit keep, input logic [7:0] nd, output bit ok);
    bit r;
    int n;
    cur = sel;
    @(negedge clk);
    tx_data = d;
    par_en  = pe;
    par_odd = po;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 2000) begin
      r = s_ready;
      @(posedge clk);
      #1;
      n++;
      if (r) ok = 1'b1;
      else @(negedge clk);
    end
    chk("accept", ok, 1);
    if (ok) begin
      chk("arm_tx", s_tx, 1);
      chk("arm_busy", s_busy, 1);
      chk("arm_ready", s_ready, 0);
    end
    if (keep) tx_data = nd;
    else if (sel) valid_b = 1'b0;
    else valid_a = 1'b0;
  endtask

  task automatic capture(input string nm, input logic [15:0] exp, input int len,
                         output int start_cyc, output int done_cyc);
    logic [15:0] got;
    int   k;
    bit   t, fin, stable_ok, hs_ok, early;
    logic last;
    got = '0; k = 0; fin = 0; stable_ok = 1; hs_ok = 1; early = 0; last = 1'b1;
    start_cyc = -1;
    done_cyc  = -1;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk);
      t = tick;
      @(posedge clk);
      #1;
      if (t && k == len) begin
        fin = 1;
        done_cyc = cyc;
        chk({nm, "_done"}, s_done, 1);
        chk({nm, "_end_tx"}, s_tx, 1);
        chk({nm, "_end_busy"}, s_busy, 0);
      end else begin
        if (s_done) early = 1;
        if (!s_busy || s_ready) hs_ok = 0;
        if (t) begin
          got[15-k] = s_tx;
          if (k == 0) start_cyc = cyc;
          k++;
        end else if (s_tx !== last) begin
          stable_ok = 0;
        end
      end
      last = s_tx;
    end
    chk({nm, "_finished"}, fin, 1);
    chk({nm, "_bits"}, got, exp);
    chk({nm, "_stable"}, stable_ok, 1);
    chk({nm, "_busy_ready"}, hs_ok, 1);
    chk({nm, "_early_done"}, early, 0);
    if (fin) begin
      @(posedge clk);
      #1;
      chk({nm, "_ready_after"}, s_ready, 1);
      chk({nm, "_done_width"}, s_done, 0);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [7:0]  d;
    bit          pe;
    bit          po;
    int          dv;
    logic [15:0] exp;
    int          len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit          ok, t;
    int          s1, d1, s2, d2, k, n, len;
    logic [15:0] e;
    int          divs[5] = '{1, 2, 3, 7, 16};

    vecs[0] = '{0, 8'hA5, 0, 0, 16, 16'b0101001011_000000, 10};
    vecs[1] = '{0, 8'hA5, 1, 0, 16, 16'b01010010101_00000, 11};
    vecs[2] = '{0, 8'hA5, 1, 1, 16, 16'b01010010111_00000, 11};
    vecs[3] = '{1, 8'h00, 0, 0, 16, 16'b00000000011_00000, 11};
    vecs[4] = '{0, 8'h81, 0, 0, 1,  16'b0100000011_000000, 10};
    vecs[5] = '{1, 8'hA5, 1, 1, 3,  16'b010100101111_0000, 12};

    rst = 1'b0; tx_data = '0; par_en = 0; par_odd = 0; valid_a = 0; valid_b = 0; cur = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_ready_a", rdy_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_ready_b", rdy_b, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      div = vecs[i].dv;
      accept_word(vecs[i].sel, vecs[i].d, vecs[i].pe, vecs[i].po, 0, 8'h00, ok);
      if (ok) capture($sformatf("vec%0d", i), vecs[i].exp, vecs[i].len, s1, d1);
    end

    // Back-to-back frames with valid held high; data change mid-frame ignored.
    div = 16;
    accept_word(0, 8'h55, 0, 0, 1, 8'h0F, ok);
    if (ok) capture("b2b_first", 16'b0101010101_000000, 10, s1, d1);
    accept_word(0, 8'h0F, 0, 0, 0, 8'h00, ok);
    if (ok) begin
      capture("b2b_second", 16'b0111100001_000000, 10, s2, d2);
      chk("b2b_gap", s2 - d1, 16);
    end

    // Reset in the middle of the data bits.
    accept_word(0, 8'hA5, 0, 0, 0, 8'h00, ok);
    k = 0; n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      t = tick;
      @(posedge clk);
      #1;
      if (t) k++;
      n++;
    end
    chk("mid_reached", k, 3);
    chk("mid_tx_before", s_tx, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", s_tx, 1);
    chk("mid_rst_busy", s_busy, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_done", s_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    accept_word(0, 8'h3C, 0, 0, 0, 8'h00, ok);
    if (ok) capture("after_rst", 16'b0001111001_000000, 10, s1, d1);

    // Randomized frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      bit          sel, pe, po;
      logic [7:0]  d;
      sel = bit'($urandom_range(0, 1));
      pe  = bit'($urandom_range(0, 1));
      po  = bit'($urandom_range(0, 1));
      d   = 8'($urandom);
      div = divs[$urandom_range(0, 4)];
      e   = model_frame(d, pe, po, sel ? 2 : 1, len);
      accept_word(sel, d, pe, po, 0, 8'h00, ok);
      if (ok) capture($sformatf("rnd%0d", r), e, len, s1, d1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
